// File: rtl/ysyx_22040088_mem_arbiter.sv
// Data-memory port arbiter: IFU and LSU share a single memory port.
// LSU has priority, limited by a streak counter so that fetch always makes
// progress. A watchdog ends a hung access with an error response.
module ysyx_22040088_mem_arbiter #(
   parameter int MAX_LSU_STREAK = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req,
   input  logic [63:0] ifu_addr,
   output logic        ifu_gnt,
   output logic        ifu_rvalid,
   output logic [63:0] ifu_rdata,
   output logic        ifu_err,
   input  logic        lsu_req,
   input  logic [63:0] lsu_addr,
   input  logic [7:0]  lsu_wen,
   input  logic [63:0] lsu_wdata,
   output logic        lsu_gnt,
   output logic        lsu_rvalid,
   output logic [63:0] lsu_rdata,
   output logic        lsu_err,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wen,
   output logic [63:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

   localparam logic        OWN_IFU    = 1'b0;
   localparam logic        OWN_LSU    = 1'b1;
   localparam logic [3:0]  STREAK_MAX = 4'(MAX_LSU_STREAK);
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic [3:0]  streak_q, streak_d;
   logic [15:0] timer_q, timer_d;
   logic [63:0] addr_q, addr_d;
   logic [7:0]  wen_q, wen_d;
   logic [63:0] wdata_q, wdata_d;

   logic lsu_win, ifu_win, expired, resp_ok, resp_err, resp;

   // Arbitration: LSU wins unless IFU is waiting and the LSU streak is used up.
   // Gated by rst so every output is quiet while reset is held.
   always_comb begin
      lsu_win = 1'b0;
      ifu_win = 1'b0;
      if (state_q == S_IDLE && !rst) begin
         lsu_win = lsu_req && !(ifu_req && streak_q == STREAK_MAX);
         ifu_win = ifu_req && !lsu_win;
      end
   end

   // Response qualification: a real response on the expiry cycle beats the watchdog.
   always_comb begin
      resp_ok  = (state_q == S_WAIT) && mem_rvalid;
      expired  = (state_q != S_IDLE) && (timer_q == TIMER_LAST);
      resp_err = expired && !resp_ok;
      resp     = resp_ok || resp_err;
   end

   // Output steering: only the owner sees the response; read data is passed straight through.
   always_comb begin
      ifu_gnt    = ifu_win;
      lsu_gnt    = lsu_win;
      ifu_rvalid = resp && (owner_q == OWN_IFU);
      lsu_rvalid = resp && (owner_q == OWN_LSU);
      ifu_err    = resp_err && (owner_q == OWN_IFU);
      lsu_err    = resp_err && (owner_q == OWN_LSU);
      ifu_rdata  = (resp_ok && owner_q == OWN_IFU) ? mem_rdata : 64'h0;
      lsu_rdata  = (resp_ok && owner_q == OWN_LSU) ? mem_rdata : 64'h0;
      mem_req    = (state_q == S_REQ) && !expired;
      mem_addr   = addr_q;
      mem_wen    = wen_q;
      mem_wdata  = wdata_q;
      busy       = (state_q != S_IDLE);
   end

   // Next-state: grant latching, streak bookkeeping, watchdog timer.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      streak_d = streak_q;
      timer_d  = timer_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (lsu_win) begin
               owner_d = OWN_LSU;
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               if (!ifu_req)                     streak_d = 4'd0;
               else if (streak_q != STREAK_MAX)  streak_d = streak_q + 4'd1;
               state_d = S_REQ;
               timer_d = 16'd0;
            end else if (ifu_win) begin
               owner_d  = OWN_IFU;
               addr_d   = ifu_addr;
               wen_d    = 8'h00;
               wdata_d  = 64'h0;
               streak_d = 4'd0;
               state_d  = S_REQ;
               timer_d  = 16'd0;
            end
         end
         S_REQ: begin
            timer_d = timer_q + 16'd1;
            if (expired)        state_d = S_IDLE;
            else if (mem_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 16'd1;
            if (resp) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latch registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_IFU;
         streak_q <= 4'd0;
         timer_q  <= 16'd0;
         addr_q   <= 64'h0;
         wen_q    <= 8'h00;
         wdata_q  <= 64'h0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
         timer_q  <= timer_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
      end
   end

endmodule

// File: doc/ysyx_22040088_mem_arbiter.md
Name: ysyx_22040088_mem_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the core.
- Each access sequences through a grant, request and response FSM. The block latches the winner's address, byte-write enables and write data, then routes the memory response back to the owner only.
- LSU has fixed priority, bounded by an anti-starvation streak counter so fetch always progresses.
- A watchdog terminates hung accesses with an error response.

Parameters:
- MAX_LSU_STREAK, 4: max consecutive LSU grants while ifu_req is high before IFU is forced to win; legal 1..15.
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT before the access is aborted with an error; legal 2..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- ifu_req  in  1  IFU access request, held until ifu_gnt
- ifu_addr  in  64  IFU read address
- ifu_gnt  out  1  one-cycle grant pulse to IFU
- ifu_rvalid  out  1  one-cycle IFU response strobe
- ifu_rdata  out  64  IFU read data, valid with ifu_rvalid
- ifu_err  out  1  IFU response error, valid with ifu_rvalid
- lsu_req  in  1  LSU access request, held until lsu_gnt
- lsu_addr  in  64  LSU address
- lsu_wen  in  8  LSU byte-write enables; 0 means read
- lsu_wdata  in  64  LSU write data
- lsu_gnt  out  1  one-cycle grant pulse to LSU
- lsu_rvalid  out  1  one-cycle LSU response strobe
- lsu_rdata  out  64  LSU read data
- lsu_err  out  1  LSU response error
- mem_req  out  1  memory request valid
- mem_addr  out  64  latched address
- mem_wen  out  8  latched byte enables (always 0 for IFU)
- mem_wdata  out  64  latched write data
- mem_ready  in  1  memory accepts request when mem_req & mem_ready
- mem_rvalid  in  1  memory response, one per accepted request, reads and writes alike
- mem_rdata  in  64  memory read data
- busy  out  1  high in REQ or WAIT

Behaviour:
- Reset (async, any state): state=IDLE, owner=IFU, streak=0, timer=0, latches=0. All outputs 0.
- States: IDLE, REQ, WAIT.
- IDLE arbitration: the grant is combinational from the requests.
  - LSU wins if lsu_req and not (ifu_req and streak==MAX_LSU_STREAK).
  - Otherwise IFU wins if ifu_req.
  - The winner's gnt pulses this cycle. Owner, addr, wen (IFU: 8'h00) and wdata are latched. Next state is REQ.
  - No request: stay in IDLE.
- Streak counter:
  - Increments (saturating at MAX_LSU_STREAK) on an LSU grant while ifu_req=1.
  - Clears on any IFU grant, and on an LSU grant with ifu_req=0.
- REQ:
  - mem_req=1 with latched fields; fields are stable while in REQ.
  - On mem_ready go to WAIT, else stay.
- WAIT:
  - On mem_rvalid: owner's rvalid=1 and owner's rdata=mem_rdata (combinational pass-through), err=0. Next state is IDLE.
  - The non-owner's rvalid stays 0 and its rdata is 0.
- Timer:
  - Clears on entry to REQ and counts each cycle in REQ or WAIT.
  - When timer==TIMEOUT_CYCLES-1 and no mem_rvalid that cycle: owner's rvalid=1, err=1, rdata=0. mem_req drops. Next state is IDLE.
  - A mem_rvalid in the same cycle as expiry wins (normal response, err=0).
- Throughput:
  - Minimum 3 cycles grant-to-response: IDLE gnt, REQ accept, WAIT rvalid.
  - A new grant is possible in the cycle after the response.
- Stray inputs:
  - mem_rvalid in IDLE or REQ is ignored (no strobe).
  - Requests arriving in REQ or WAIT wait; gnt only ever pulses in IDLE.
- A requester deasserting req before gnt withdraws cleanly, with no state change.
- After gnt, the requester may change addr/wen/wdata freely.

Test Plan:
- IFU-only read: ifu_req, ifu_addr=0x8000_0000. Memory is ready immediately with rvalid a cycle later and rdata=0xDEAD_BEEF_0000_0013.
  - ifu_gnt pulses at cycle 0, mem_req at cycle 1 with addr 0x8000_0000 and wen 0, ifu_rvalid at cycle 2 with that data.
  - lsu_rvalid stays 0 throughout.
- Simultaneous requests (LSU store: wen=0xFF, wdata=0x1122334455667788) with MAX_LSU_STREAK=4:
  - The LSU is granted first with mem_wen=0xFF.
  - After 4 back-to-back LSU grants with ifu_req held, the 5th arbitration grants IFU and the streak returns to 0.
- Backpressure: mem_ready low for 10 cycles.
  - mem_req and the latched fields stay constant across all 10 cycles, and busy=1.
  - Changing lsu_addr after gnt does not alter mem_addr.
- Timeout with TIMEOUT_CYCLES=8: memory never responds.
  - lsu_rvalid=1, lsu_err=1, lsu_rdata=0 exactly 8 cycles after entering REQ, then the FSM returns to IDLE.
  - In a second run, mem_rvalid arrives on the expiry cycle: the required result is err=0 with the real data.
- Async reset asserted mid-WAIT:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a late mem_rvalid produces no strobe, and a fresh ifu_req is granted in the next cycle.
